// File: rtl/tick_gen_multi_if.sv
// Control and output bundle for the multi-channel tick generator.
// The master drives enables, restart and divisor writes; the slave (the
// generator) returns the per-channel tick strobes and square outputs.
interface tick_gen_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 23,
    parameter int SEL_W = 2
);
    logic             en;
    logic [NCH-1:0]   ch_en;
    logic             restart;
    logic             load;
    logic [SEL_W-1:0] load_sel;
    logic [CNT_W-1:0] load_div;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;

    modport master (
        output en, ch_en, restart, load, load_sel, load_div,
        input  tick, sq
    );

    modport slave (
        input  en, ch_en, restart, load, load_sel, load_div,
        output tick, sq
    );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel clock divider: NCH independent channels, each producing a
// one-cycle tick every eff_div active cycles and a square wave toggling on
// every tick. Divisors are run-time reloadable; channels can be paused.

// One divider channel. Priority: clr > restart > load > count.
module tick_gen_ch #(
    parameter int          CNT_W       = 23,
    parameter int unsigned DEFAULT_DIV = 5000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             active,
    input  logic             restart,
    input  logic             load_hit,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] eff_div;
    logic             wrap;

    // A divisor of 0 behaves like 1; eff_div is therefore never 0, so
    // eff_div-1 cannot underflow and cnt stays within [0, eff_div-1].
    always_comb begin
        eff_div = (div_reg == '0) ? CNT_W'(1) : div_reg;
        wrap    = (cnt == eff_div - CNT_W'(1));
    end

    // Counter, divisor and output registers for this channel.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt     <= '0;
            div_reg <= CNT_W'(DEFAULT_DIV);
            tick    <= 1'b0;
            sq      <= 1'b1;
        end else if (restart) begin
            // Divisor is kept; any load this cycle is dropped.
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b1;
        end else if (load_hit) begin
            // A load beats a wrap in the same cycle: no tick, sq untouched.
            div_reg <= load_div;
            cnt     <= '0;
            tick    <= 1'b0;
        end else if (active) begin
            if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            // Paused: cnt and sq hold so phase survives the pause.
            tick <= 1'b0;
        end
    end
endmodule

module tick_gen_multi #(
    parameter int          NCH         = 4,
    parameter int          CNT_W       = 23,
    parameter int          SEL_W       = 2,
    parameter int unsigned DEFAULT_DIV = 5000000
) (
    input  logic            clk,
    input  logic            clr,
    tick_gen_multi_if.slave bus
);
    logic [NCH-1:0] active;
    logic [NCH-1:0] load_hit;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] sq_q;

    if ((2 ** SEL_W) < NCH) begin : g_sel_chk
        $error("tick_gen_multi: SEL_W too narrow to address all channels");
    end

    // One channel per lane; out-of-range load_sel matches no lane and is
    // silently ignored.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign active[i]   = bus.en & bus.ch_en[i];
        assign load_hit[i] = bus.load & (bus.load_sel == SEL_W'(i));

        tick_gen_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .clr      (clr),
            .active   (active[i]),
            .restart  (bus.restart),
            .load_hit (load_hit[i]),
            .load_div (bus.load_div),
            .tick     (tick_q[i]),
            .sq       (sq_q[i])
        );
    end

    assign bus.tick = tick_q;
    assign bus.sq   = sq_q;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed scenarios followed by random stimulus,
// every cycle compared against a reference model that tracks, per channel,
// the number of active edges since the last phase reset and derives tick
// and sq arithmetically from that count.
module tb_tick_gen_multi;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int SEL_W = 3;
    localparam int DDIV  = 4;

    logic clk = 1'b0;
    logic clr;

    tick_gen_multi_if #(.NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    tick_gen_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DEFAULT_DIV(DDIV)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int mdiv [NCH];   // programmed divisor
    int mn   [NCH];   // active edges since last restart/load/reset
    bit mbase[NCH];   // sq level at the last phase reset
    bit mtk  [NCH];   // registered tick

    int total  = 0;
    int passed = 0;
    int failed = 0;

    function automatic int eff(int i);
        return (mdiv[i] == 0) ? 1 : mdiv[i];
    endfunction

    // Number of completed periods decides how many times sq has flipped.
    function automatic bit msq(int i);
        return mbase[i] ^ bit'((mn[i] / eff(i)) % 2);
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = mtk[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_sq();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = msq(i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mdiv[i] = DDIV; mn[i] = 0; mbase[i] = 1'b1; mtk[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs now on the bus.
    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            if (bus.restart) begin
                mn[i] = 0; mbase[i] = 1'b1; mtk[i] = 1'b0;
            end else if (bus.load && int'(bus.load_sel) == i) begin
                mbase[i] = msq(i);
                mn[i]    = 0;
                mdiv[i]  = int'(bus.load_div);
                mtk[i]   = 1'b0;
            end else if (bus.en && bus.ch_en[i]) begin
                mn[i]  = mn[i] + 1;
                mtk[i] = ((mn[i] % eff(i)) == 0);
            end else begin
                mtk[i] = 1'b0;
            end
        end
    endtask

    task automatic check(string tag, logic [NCH-1:0] got, logic [NCH-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cycle(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, " tick"}, bus.tick, exp_tick());
        check({tag, " sq"},   bus.sq,   exp_sq());
    endtask

    task automatic run(int n, string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic drive(bit e, logic [NCH-1:0] ce, bit rs, bit ld,
                         logic [SEL_W-1:0] sel, logic [CNT_W-1:0] dv);
        bus.en = e; bus.ch_en = ce; bus.restart = rs;
        bus.load = ld; bus.load_sel = sel; bus.load_div = dv;
    endtask

    initial begin
        clr = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        model_reset();
        #12;
        check("reset tick", bus.tick, '0);
        check("reset sq",   bus.sq,   4'b1111);
        clr = 1'b0;

        // Count from reset, then clr mid-count, then full periods.
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);
        run(6, "count");
        #3 clr = 1'b1;
        #1;
        model_reset();
        check("midclr tick", bus.tick, '0);
        check("midclr sq",   bus.sq,   4'b1111);
        #1 clr = 1'b0;
        run(13, "postclr");

        // Per-channel divisors: ch1=3, ch2=1, ch3=0.
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd1, 8'd3); cycle("ld1");
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd2, 8'd1); cycle("ld2");
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd3, 8'd0); cycle("ld3");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);
        run(12, "divs");

        // Pause ch0 after 2 counts for 10 cycles, then resume.
        drive(1'b1, 4'hF, 1'b1, 1'b0, '0, '0); cycle("rs_pause");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0); run(2, "pre_pause");
        drive(1'b1, 4'hE, 1'b0, 1'b0, '0, '0); run(10, "paused");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0); run(8, "resumed");

        // Load ch0=6 exactly in its wrap cycle.
        drive(1'b1, 4'hF, 1'b1, 1'b0, '0, '0); cycle("rs_coll");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0); run(3, "pre_coll");
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd0, 8'd6); cycle("coll");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0); run(14, "post_coll");

        // Restart beats a simultaneous load; ch2 keeps divisor 3.
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd2, 8'd3); cycle("ld2_3");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);     run(4, "ch2_3");
        drive(1'b1, 4'hF, 1'b1, 1'b1, 3'd2, 8'd7); cycle("rs_ld");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);     run(8, "post_rs_ld");

        // Out-of-range select changes nothing.
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd5, 8'd9); cycle("sel5");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);     run(8, "post_sel5");

        // Global enable low freezes everything.
        drive(1'b0, 4'hF, 1'b0, 1'b0, '0, '0); run(20, "en_off");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0); run(4, "en_on");

        // Maximum divisor on ch3.
        drive(1'b1, 4'hF, 1'b1, 1'b0, '0, '0);     cycle("rs_max");
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'd3, 8'd255); cycle("ld_max");
        drive(1'b1, 4'hF, 1'b0, 1'b0, '0, '0);     run(515, "maxdiv");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) != 0),
                  NCH'($urandom),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 5) == 0),
                  SEL_W'($urandom_range(0, 7)),
                  CNT_W'($urandom_range(0, 9)));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised multi-channel successor to the single 0.1 s toggle divider used by the game timing logic.
- Provides NCH independent divided-clock channels, each giving a one-cycle tick strobe and a 50% square output.
- Each channel has a divisor that can be reloaded at run time, a per-channel enable (pause/resume), and a global synchronous restart.
- Typical uses: bird fall rate, pipe scroll speed, score blink and frame tick, all driven from the 100 MHz system clock.

Parameters:
- NCH, 4, number of channels.
- CNT_W, 23, counter and divisor width in bits.
- SEL_W, 2, width of the channel select; must satisfy 2^SEL_W >= NCH.
- DEFAULT_DIV, 5000000, divisor loaded into every channel on reset. 5000000 gives a 0.1 s square period at 100 MHz.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- en  in  1  global count enable.
- ch_en  in  NCH  per-channel count enable.
- restart  in  1  synchronous restart of all channels.
- load  in  1  divisor write strobe.
- load_sel  in  SEL_W  channel index for the write.
- load_div  in  CNT_W  new divisor value.
- tick  out  NCH  one-cycle strobe per channel period.
- sq  out  NCH  square output; toggles once per channel period.

Behaviour:
- Reset (clr high, asynchronous, dominant over everything):
  - for every channel: cnt=0, div_reg=DEFAULT_DIV, tick=0, sq=1.
  - State stays held while clr is high.
  - On clr deassertion, counting starts at the next clk edge.
- All outputs are registered. No combinational path from inputs to outputs.
- A channel is active when en=1 and ch_en[i]=1.
- Active channel, each clk edge:
  - If cnt[i] == eff_div[i]-1: cnt[i]<=0, tick[i]<=1, sq[i]<=~sq[i].
  - Otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
- eff_div = div_reg, except that a div_reg of 0 is treated as 1.
  - Divisor 0 or 1 therefore gives tick high every cycle and sq toggling every cycle.
- Periods:
  - tick period = eff_div cycles.
  - sq period = 2*eff_div cycles.
- First tick after reset or restart: tick rises on the eff_div-th active edge.
  - Example: div=4 → tick high in cycle 4, 8, 12, … counting from the first active edge as 1.
- Inactive channel (pause):
  - cnt and sq hold; tick<=0.
  - On resume, counting continues from the held cnt. Phase is not lost.
- restart=1 (synchronous):
  - all channels: cnt<=0, tick<=0, sq<=1.
  - div_reg values are kept.
  - restart overrides counting and load in that cycle; any load in the same cycle is discarded.
- load=1 with load_sel<NCH:
  - div_reg[load_sel]<=load_div, cnt[load_sel]<=0, tick[load_sel]<=0, sq unchanged.
  - A load is accepted even when the channel is inactive.
  - If load hits a channel in the same cycle it would wrap: load wins, no tick, no sq toggle.
- load with load_sel>=NCH: ignored; no state change.
- Other channels are unaffected by a load.
- Counter arithmetic is CNT_W-bit unsigned. cnt never exceeds eff_div-1, so no wrap-around beyond the divisor is possible.
- A divisor value of 2^CNT_W-1 must be supported.

Test Plan:
- Reset values: bench DEFAULT_DIV=4, assert clr mid-count → immediately tick=0, sq=4'b1111; after release with en=1, ch_en=4'hF → tick on edges 4, 8, 12 and sq toggles 1→0→1.
- Per-channel divisors: load ch1=3, ch2=1, ch3=0 → ch1 ticks every 3 cycles; ch2 and ch3 tick every cycle with sq toggling every cycle; ch0 keeps a period of 4.
- Pause/resume: ch0 div=4; drop ch_en[0] after 2 counts for 10 cycles → no tick, sq held; after resume the next tick comes 2 active cycles later.
- Load collision: load ch0=6 in the cycle where cnt0==3 → no tick that cycle; the next ch0 tick is 6 cycles later; sq0 unchanged by the load.
- Restart priority: restart=1 together with load ch2=7 → all cnt=0 and sq=1; ch2 keeps its old divisor; the first tick after restart follows that old divisor. Separately, load_sel=5 with NCH=4, SEL_W=3 → no change.
- Global enable: en=0 with ch_en=4'hF for 20 cycles → tick stays 0 and sq stays constant on all channels.
